// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-stage controller: FSM states, hold-flag codes
// and funct3 load/store encodings.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HOLD_NONE = 2'b00,
        HOLD_SET  = 2'b01,
        HOLD_HOLD = 2'b10
    } hold_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_ILL = 3'b111
    } funct3_e;

    // Store size from funct3[1:0] (SB/SH/SW/SD).
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-bus interface between the memory-stage controller (master) and memory (slave).
// Handshake: a request transfers in the cycle mem_req_o && mem_ready_i; the response
// is the single cycle with mem_rvalid_i, where mem_rdata_i/mem_err_i are valid.
interface mem_access_ctrl_if;
    logic        mem_req_o;
    logic        mem_ready_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic [1:0]  mem_size_o;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        mem_err_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_size_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_size_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
endinterface

// File: rtl/mem_access_ctrl_align.sv
// Combinational lane alignment (mem_align): store strobes/data shift, load
// shift with sign/zero extension, and the misalignment flag.
module mem_access_ctrl_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  offset_i,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  wstrb_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o,
    output logic        misalign_o
);
    logic [5:0]  sh;
    logic [63:0] rsh;
    logic [7:0]  base;

    assign sh      = {offset_i, 3'b000};
    assign wdata_o = wdata_i << sh;
    assign rsh     = rdata_i >> sh;

    always_comb begin
        base       = 8'h00;
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            SZ_B: begin base = 8'h01; misalign_o = 1'b0;             end
            SZ_H: begin base = 8'h03; misalign_o = offset_i[0];      end
            SZ_W: begin base = 8'h0F; misalign_o = |offset_i[1:0];   end
            SZ_D: begin base = 8'hFF; misalign_o = |offset_i;        end
            default: ;
        endcase
        wstrb_o = we_i ? (base << offset_i) : 8'h00;
    end

    always_comb begin
        rdata_o = rsh;
        case (funct3_i)
            F3_LB:   rdata_o = {{56{rsh[7]}},  rsh[7:0]};
            F3_LH:   rdata_o = {{48{rsh[15]}}, rsh[15:0]};
            F3_LW:   rdata_o = {{32{rsh[31]}}, rsh[31:0]};
            F3_LBU:  rdata_o = {56'h0, rsh[7:0]};
            F3_LHU:  rdata_o = {48'h0, rsh[15:0]};
            F3_LWU:  rdata_o = {32'h0, rsh[31:0]};
            default: rdata_o = rsh;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: issues one bus request per load/store held in EX_MEM,
// stalls the pipeline until response or timeout, and returns aligned load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_ram_i,
    input  logic                write_ram_i,
    input  logic [31:0]         inst_i,
    input  logic [31:0]         addr_i,
    input  logic [63:0]         wdata_i,
    mem_access_ctrl_if.master   bus,
    output logic [1:0]          hold_flag_o,
    output logic                load_valid_o,
    output logic [63:0]         load_data_o,
    output logic                err_o,
    output state_e              state_o
);
    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q, load_data_q;
    logic [2:0]  f3_q;
    logic        we_q, err_q;

    logic        access, illegal, misalign, go_req, go_err, resp, timeout;
    logic        idle;
    logic [2:0]  sel_f3, sel_off;
    logic [7:0]  al_wstrb;
    logic [63:0] al_wdata, al_rdata;
    logic        unused_inst;

    assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

    // In IDLE the aligner judges the incoming access; afterwards it works from the latches.
    assign idle    = (state_q == ST_IDLE);
    assign sel_f3  = idle ? inst_i[14:12] : f3_q;
    assign sel_off = idle ? addr_i[2:0]   : addr_q[2:0];

    mem_access_ctrl_align u_align (
        .funct3_i   (sel_f3),
        .offset_i   (sel_off),
        .we_i       (we_q),
        .wdata_i    (wdata_q),
        .rdata_i    (bus.mem_rdata_i),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (misalign)
    );

    assign access  = read_ram_i ^ write_ram_i;
    assign illegal = (read_ram_i & write_ram_i) | (access & (inst_i[14:12] == F3_ILL));
    assign go_err  = illegal | (access & misalign);
    assign go_req  = access & ~illegal & ~misalign;
    // A response in REQ only counts when the request is accepted in the same cycle.
    assign resp    = bus.mem_rvalid_i & ((state_q == ST_WAIT) | bus.mem_ready_i);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_err)      state_d = ST_DONE;
                else if (go_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (resp || timeout)      state_d = ST_DONE;
                else if (bus.mem_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: if (resp || timeout) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_flag_o     = HOLD_NONE;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = 32'h0;
        bus.mem_wdata_o = 64'h0;
        bus.mem_wstrb_o = 8'h0;
        bus.mem_size_o  = 2'b00;
        load_valid_o    = 1'b0;
        err_o           = 1'b0;
        case (state_q)
            ST_IDLE: if (go_req) hold_flag_o = HOLD_HOLD;
            ST_REQ: begin
                hold_flag_o     = HOLD_HOLD;
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_addr_o  = {addr_q[31:3], 3'b000};
                bus.mem_wdata_o = al_wdata;
                bus.mem_wstrb_o = al_wstrb;
                bus.mem_size_o  = f3_q[1:0];
            end
            ST_WAIT: hold_flag_o = HOLD_HOLD;
            ST_DONE: begin
                load_valid_o = ~we_q & ~err_q;
                err_o        = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            addr_q      <= 32'h0;
            wdata_q     <= 64'h0;
            f3_q        <= 3'b000;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= 64'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_req) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        f3_q    <= inst_i[14:12];
                        we_q    <= write_ram_i;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (go_err) begin
                        we_q  <= write_ram_i;
                        err_q <= 1'b1;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (resp) begin
                        err_q <= bus.mem_err_i;
                        if (!we_q && !bus.mem_err_i) load_data_q <= al_rdata;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_data_o = load_data_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level
// model of request count, timeout, strobes, lane shifts and load extension.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read_ram = 1'b0, write_ram = 1'b0;
    logic [31:0] inst = 32'h0, addr = 32'h0;
    logic [63:0] wdata = 64'h0;
    logic [1:0]  hold;
    logic        load_valid, err;
    logic [63:0] load_data;
    state_e      state;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .read_ram_i   (read_ram),
        .write_ram_i  (write_ram),
        .inst_i       (inst),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .bus          (bus.master),
        .hold_flag_o  (hold),
        .load_valid_o (load_valid),
        .load_data_o  (load_data),
        .err_o        (err),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_ld = 64'h0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] dw);
        logic [63:0] v, mask;
        int w;
        v = dw >> (off * 8);
        w = 8 << f3[1:0];
        mask = (w == 64) ? ~64'h0 : ((64'h1 << w) - 64'h1);
        if (!f3[2] && v[w-1]) return (v & mask) | ~mask;
        return v & mask;
    endfunction

    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [63:0] wd,
                              input int r_lat, input int v_lat,
                              input logic [63:0] rdata, input logic berr);
        logic bad, exp_err, exp_lv;
        int   off, total, reqc, resp_k, nb;
        logic [7:0] strb;
        off  = int'(a[2:0]);
        bad  = (rd && wr) || (f3 == 3'b111) || ((off % (1 << f3[1:0])) != 0);
        nb   = 1 << f3[1:0];
        strb = wr ? 8'(((1 << nb) - 1) << off) : 8'h00;
        @(negedge clk);
        read_ram = rd; write_ram = wr; addr = a; wdata = wd;
        inst = $urandom(); inst[14:12] = f3;
        bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        #1;
        check_eq("idle_hold", hold, bad ? 64'd0 : 64'd2);
        check_eq("idle_req", bus.mem_req_o, 0);
        exp_err = 1'b1;
        if (!bad) begin
            resp_k = r_lat + v_lat;
            if (resp_k <= T - 1) begin total = resp_k + 1; exp_err = berr; end
            else                 begin total = T;          exp_err = 1'b1; end
            reqc = (r_lat + 1 < total) ? r_lat + 1 : total;
            for (int k = 0; k < total; k++) begin
                @(negedge clk);
                bus.mem_ready_i  = (k == r_lat);
                bus.mem_rvalid_i = (k == resp_k);
                bus.mem_rdata_i  = (k == resp_k) ? rdata : {$urandom(), $urandom()};
                bus.mem_err_i    = (k == resp_k) ? berr : 1'($urandom_range(0, 1));
                #1;
                check_eq("busy_req", bus.mem_req_o, (k < reqc) ? 64'd1 : 64'd0);
                check_eq("busy_hold", hold, 2);
                check_eq("busy_lv", load_valid, 0);
                check_eq("busy_err", err, 0);
                if (k < reqc) begin
                    check_eq("req_we", bus.mem_we_o, wr);
                    check_eq("req_addr", bus.mem_addr_o, a & ~32'h7);
                    check_eq("req_wdata", bus.mem_wdata_o, wd << (off * 8));
                    check_eq("req_wstrb", bus.mem_wstrb_o, strb);
                    check_eq("req_size", bus.mem_size_o, f3[1:0]);
                end
            end
        end
        exp_lv = rd && !wr && !exp_err;
        if (exp_lv) begin
            exp_ld = model_load(f3, off, rdata);
            exp_q.push_back(exp_ld);
        end
        @(negedge clk);
        bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        read_ram = 1'b0; write_ram = 1'b0;
        #1;
        check_eq("done_state", 64'(state), 64'(ST_DONE));
        check_eq("done_hold", hold, 0);
        check_eq("done_req", bus.mem_req_o, 0);
        check_eq("done_lv", load_valid, exp_lv);
        check_eq("done_err", err, exp_err);
        if (load_valid && exp_q.size() > 0) check_eq("ld_data", load_data, exp_q.pop_front());
        @(negedge clk);
        #1;
        check_eq("after_state", 64'(state), 64'(ST_IDLE));
        check_eq("after_lv", load_valid, 0);
        check_eq("after_err", err, 0);
        check_eq("ld_keep", load_data, exp_ld);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_hold"}, hold, 0);
        check_eq({tag, "_req"}, bus.mem_req_o, 0);
        check_eq({tag, "_we"}, bus.mem_we_o, 0);
        check_eq({tag, "_addr"}, bus.mem_addr_o, 0);
        check_eq({tag, "_wdata"}, bus.mem_wdata_o, 0);
        check_eq({tag, "_wstrb"}, bus.mem_wstrb_o, 0);
        check_eq({tag, "_size"}, bus.mem_size_o, 0);
        check_eq({tag, "_lv"}, load_valid, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_ldata"}, load_data, 0);
        check_eq({tag, "_state"}, 64'(state), 64'(ST_IDLE));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = 64'h0; bus.mem_err_i = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_access(1, 0, 3'b011, 32'h8000_0008, 64'h0, 0, 2, 64'h1122_3344_5566_7788, 0);
        run_access(1, 0, 3'b000, 32'h8000_0003, 64'h0, 0, 0, 64'h0000_0000_80FF_0000, 0);
        run_access(1, 0, 3'b100, 32'h8000_0003, 64'h0, 1, 1, 64'h0000_0000_80FF_0000, 0);
        run_access(0, 1, 3'b001, 32'h8000_0006, 64'hABCD, 0, 1, 64'h0, 0);
        run_access(1, 0, 3'b010, 32'h8000_0002, 64'h0, 0, 0, 64'h0, 0);
        run_access(1, 1, 3'b010, 32'h8000_0000, 64'h0, 0, 0, 64'h0, 0);
        run_access(1, 0, 3'b011, 32'h8000_0010, 64'h0, 100, 0, 64'h0, 0);
        run_access(1, 0, 3'b111, 32'h8000_0010, 64'h0, 0, 0, 64'h0, 0);

        // Reset asserted while waiting for the response.
        @(negedge clk);
        read_ram = 1'b1; addr = 32'h8000_0020; inst = 32'h0000_3003;
        @(negedge clk);
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        #1;
        check_eq("pre_rst_state", 64'(state), 64'(ST_WAIT));
        #1;
        rst = 1'b0; read_ram = 1'b0;
        #1;
        exp_ld = 64'h0;
        exp_q.delete();
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D; bus.mem_err_i = 1'b1;
        #1;
        check_eq("late_lv", load_valid, 0);
        check_eq("late_err", err, 0);
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0; bus.mem_err_i = 1'b0;
        #1;
        check_all_zero("late_idle");

        for (int i = 0; i < 160; i++) begin
            int          kind, off, sz;
            logic        rd, wr, be;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 19);
            rd = (kind == 0) || (kind <= 10);
            wr = (kind == 0) || (kind > 10);
            f3 = rd && !wr ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            sz = 1 << f3[1:0];
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off - (off % sz);
            a = {1'b1, 25'($urandom()), 3'b000, 3'(off)};
            be = ($urandom_range(0, 9) == 0);
            run_access(rd, wr, f3, a, {$urandom(), $urandom()},
                       $urandom_range(0, 4), $urandom_range(0, 3),
                       {$urandom(), $urandom()}, be);
        end

        check_eq("q_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
